debug_unit: RTL

DEBUG_UNIT -- requirements
Module: debug_unit

---
 rtl/debug_pkg.sv | 40 ++++
 rtl/debug_word_tx.sv | 74 +++++++
 rtl/debug_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared constants for the UART debug unit: command codes, one-hot state encoding and the
// HALT opcode that terminates an instruction-memory load.
package debug_pkg;

  localparam int unsigned CmdWriteIm  = 1;
  localparam int unsigned CmdRun      = 2;
  localparam int unsigned CmdStepMode = 3;
  localparam int unsigned CmdReadBr   = 4;
  localparam int unsigned CmdReadMem  = 5;
  localparam int unsigned CmdReadPc   = 6;
  localparam int unsigned CmdStep     = 7;
  localparam int unsigned CmdCont     = 8;

  localparam int unsigned BitIdle     = 0;
  localparam int unsigned BitLoadIm   = 1;
  localparam int unsigned BitRun      = 2;
  localparam int unsigned BitStepWait = 3;
  localparam int unsigned BitStep     = 4;
  localparam int unsigned BitSendPc   = 5;
  localparam int unsigned BitSendBr   = 6;
  localparam int unsigned BitSendMem  = 7;
  localparam int unsigned BitHalted   = 8;
  localparam int unsigned BitDumpEnd  = 9;

  localparam logic [5:0] HaltOpcode = 6'b111111;

  typedef enum logic [9:0] {
    StIdle     = 10'b1 << BitIdle,
    StLoadIm   = 10'b1 << BitLoadIm,
    StRun      = 10'b1 << BitRun,
    StStepWait = 10'b1 << BitStepWait,
    StStep     = 10'b1 << BitStep,
    StSendPc   = 10'b1 << BitSendPc,
    StSendBr   = 10'b1 << BitSendBr,
    StSendMem  = 10'b1 << BitSendMem,
    StHalted   = 10'b1 << BitHalted,
    StDumpEnd  = 10'b1 << BitDumpEnd
  } state_e;

endpackage

// File: rtl/debug_word_tx.sv
// Sends one 32-bit word over the UART transmitter as bytes, MSB first, waiting for each
// byte-sent tick before issuing the next start pulse.
module debug_word_tx
  import debug_pkg::*;
#(
  parameter int unsigned NB_DATA = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [31:0]        i_word,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done
);

  localparam int unsigned NbBytes = 32 / NB_DATA;

  typedef enum logic [1:0] {TxIdle, TxStart, TxWait} tx_state_e;

  tx_state_e   state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    o_done  = 1'b0;
    unique case (state_q)
      TxIdle: begin
        if (i_start) begin
          shift_d = i_word;
          cnt_d   = '0;
          state_d = TxStart;
        end
      end
      TxStart: state_d = TxWait;
      TxWait: begin
        if (i_tx_done) begin
          shift_d = shift_q << NB_DATA;
          if (cnt_q == 2'(NbBytes - 1)) begin
            o_done  = 1'b1;
            state_d = TxIdle;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = TxStart;
          end
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= TxIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Current byte stays on the top of the shift register until its tick arrives.
  assign o_tx_data  = shift_q[31 -: NB_DATA];
  assign o_tx_start = (state_q == TxStart);
  assign o_busy     = (state_q != TxIdle);

endmodule

// File: rtl/debug_unit.sv
// UART debug unit: loads instruction memory, runs or single-steps the pipeline and dumps
// PC, register bank and data memory back over the UART.
module debug_unit
  import debug_pkg::*;
#(
  parameter int unsigned NB_DATA      = 8,
  parameter int unsigned NB_MEM_DEPTH = 8,
  parameter int unsigned RB_ADDR      = 5,
  parameter int unsigned NB_STATE     = 10,
  parameter int unsigned DM_WORDS     = 32
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_DATA-1:0]      i_rx_data,
  input  logic                    i_rx_done,
  output logic [NB_DATA-1:0]      o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  output logic                    o_im_we,
  output logic [NB_MEM_DEPTH-1:0] o_im_addr,
  output logic [31:0]             o_im_data,
  output logic                    o_cpu_enable,
  input  logic                    i_halt,
  input  logic [31:0]             i_pc,
  output logic [RB_ADDR-1:0]      o_rb_addr,
  input  logic [31:0]             i_rb_data,
  output logic [4:0]              o_dm_addr,
  input  logic [31:0]             i_dm_data,
  output logic [NB_STATE-1:0]     o_state,
  output logic                    o_halt
);

  localparam logic [NB_MEM_DEPTH-1:0] LastAddr = NB_MEM_DEPTH'((2 ** NB_MEM_DEPTH) - 4);
  localparam logic [4:0] LastBr  = 5'((2 ** RB_ADDR) - 1);
  localparam logic [4:0] LastMem = 5'(DM_WORDS - 1);

  state_e                  state_q, state_d, ret_q, ret_d;
  logic                    dump_all_q, dump_all_d, halt_q, halt_d, step_halt_q, step_halt_d;
  logic [4:0]              idx_q, idx_d;
  logic                    fetch_wait_q, fetch_wait_d, launched_q, launched_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]             asm_q, asm_d, im_data_q, im_data_d;
  logic [NB_MEM_DEPTH-1:0] word_addr_q, word_addr_d, im_addr_q, im_addr_d;
  logic                    im_we_q, im_we_d;
  logic                    word_start, word_busy, word_done, finish;
  logic [31:0]             word_in;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    dump_all_d   = dump_all_q;
    halt_d       = halt_q;
    step_halt_d  = step_halt_q;
    idx_d        = idx_q;
    fetch_wait_d = fetch_wait_q;
    launched_d   = launched_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    word_addr_d  = word_addr_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_data_d    = im_data_q;
    word_start   = 1'b0;
    word_in      = i_pc;
    finish       = 1'b0;
    unique case (state_q)
      StIdle, StHalted, StStepWait: begin
        if (i_rx_done) begin
          ret_d      = state_q;
          dump_all_d = 1'b0;
          case (i_rx_data)
            NB_DATA'(CmdWriteIm):  if (state_q != StStepWait) state_d = StLoadIm;
            NB_DATA'(CmdRun):      if (state_q == StIdle) state_d = StRun;
            NB_DATA'(CmdStepMode): if (state_q == StIdle) state_d = StStepWait;
            NB_DATA'(CmdReadBr):   state_d = StSendBr;
            NB_DATA'(CmdReadMem):  state_d = StSendMem;
            NB_DATA'(CmdReadPc):   state_d = StSendPc;
            NB_DATA'(CmdStep):     if (state_q == StStepWait) state_d = StStep;
            NB_DATA'(CmdCont):     if (state_q == StStepWait) state_d = StRun;
            default: ;
          endcase
        end
      end
      StLoadIm: begin
        if (i_rx_done) begin
          asm_d      = (asm_q << NB_DATA) | 32'(i_rx_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            im_we_d     = 1'b1;
            im_addr_d   = word_addr_q;
            im_data_d   = asm_d;
            word_addr_d = word_addr_q + NB_MEM_DEPTH'(4);
            if (asm_d[31:26] == HaltOpcode || word_addr_q == LastAddr) state_d = StIdle;
          end
        end
      end
      StRun: begin
        if (i_halt) begin
          halt_d     = 1'b1;
          dump_all_d = 1'b1;
          ret_d      = StHalted;
          state_d    = StSendPc;
        end
      end
      StStep: begin
        step_halt_d = i_halt;
        dump_all_d  = 1'b1;
        ret_d       = StStepWait;
        state_d     = StSendPc;
      end
      StSendPc: begin
        step_halt_d = step_halt_q | i_halt;
        if (!launched_q && !word_busy) begin
          word_start = 1'b1;
          launched_d = 1'b1;
        end else if (word_done) begin
          if (dump_all_q) state_d = StSendBr;
          else finish = 1'b1;
        end
      end
      StSendBr, StSendMem: begin
        step_halt_d = step_halt_q | i_halt;
        word_in     = (state_q == StSendBr) ? i_rb_data : i_dm_data;
        if (word_done) begin
          if (state_q == StSendBr && idx_q == LastBr) begin
            if (dump_all_q) state_d = StSendMem;
            else finish = 1'b1;
          end else if (state_q == StSendMem && idx_q == LastMem) begin
            finish = 1'b1;
          end else begin
            idx_d        = idx_q + 5'd1;
            fetch_wait_d = 1'b1;
            launched_d   = 1'b0;
          end
        end else if (!launched_q && !word_busy) begin
          // One idle cycle lets the synchronous read port catch up with the new address.
          if (fetch_wait_q) begin
            fetch_wait_d = 1'b0;
          end else begin
            word_start = 1'b1;
            launched_d = 1'b1;
          end
        end
      end
      StDumpEnd: state_d = ret_q;
      default:   state_d = StIdle;
    endcase

    if (finish) begin
      if (!dump_all_q) begin
        state_d = StDumpEnd;
      end else if (ret_q == StHalted || step_halt_d) begin
        state_d = StHalted;
        halt_d  = 1'b1;
      end else begin
        state_d = ret_q;
      end
    end
    if (state_d != state_q) begin
      idx_d        = '0;
      fetch_wait_d = 1'b1;
      launched_d   = 1'b0;
    end
    if (state_d == StLoadIm && state_q != StLoadIm) begin
      byte_cnt_d  = '0;
      word_addr_d = '0;
      halt_d      = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= StIdle;
      ret_q        <= StIdle;
      dump_all_q   <= 1'b0;
      halt_q       <= 1'b0;
      step_halt_q  <= 1'b0;
      idx_q        <= '0;
      fetch_wait_q <= 1'b0;
      launched_q   <= 1'b0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      word_addr_q  <= '0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      dump_all_q   <= dump_all_d;
      halt_q       <= halt_d;
      step_halt_q  <= step_halt_d;
      idx_q        <= idx_d;
      fetch_wait_q <= fetch_wait_d;
      launched_q   <= launched_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      word_addr_q  <= word_addr_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_data_q    <= im_data_d;
    end
  end

  debug_word_tx #(
    .NB_DATA(NB_DATA)
  ) u_word_tx (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_start   (word_start),
    .i_word    (word_in),
    .o_busy    (word_busy),
    .o_done    (word_done),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .i_tx_done (i_tx_done)
  );

  assign o_cpu_enable = (state_q == StRun) || (state_q == StStep);
  assign o_state      = NB_STATE'(state_q);
  assign o_halt       = halt_q;
  assign o_im_we      = im_we_q;
  assign o_im_addr    = im_addr_q;
  assign o_im_data    = im_data_q;
  assign o_rb_addr    = RB_ADDR'(idx_q);
  assign o_dm_addr    = idx_q;

endmodule
